// File: rtl/dms_dlf.sv
// rtl/dms_dlf.sv - Decimating bang-bang PI digital loop filter for a DCO/phase interpolator
//
// Purpose:
//   Sums DECIM phase-detector votes per window. At each window close it updates
//   the integrator by (S <<< KI_SHIFT). It then forms the control word as
//   integ + (S <<< KP_SHIFT). Both results are saturated to W_OUT signed bits.
//
// Optional feature:
//   DMS_DLF_SAT_FLAG_EN - adds the sticky integrator saturation flags sat_hi / sat_lo.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   pd_vld    in   qualifies pd_up / pd_dn
//   pd_up     in   early vote
//   pd_dn     in   late vote
//   freeze    in   holds the integrator at window close (proportional path still active)
//   ctrl      out  signed control word, W_OUT bits
//   ctrl_vld  out  one-cycle pulse when ctrl updates
//   sat_hi    out  sticky: integrator clamped at the high rail (macro only)
//   sat_lo    out  sticky: integrator clamped at the low rail  (macro only)
//   integ     out  signed integrator state, W_OUT bits

module dms_dlf #(
    parameter int W_OUT    = 12,
    parameter int DECIM    = 4,
    parameter int KP_SHIFT = 2,
    parameter int KI_SHIFT = 0,
    parameter int INIT     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pd_vld,
    input  logic                    pd_up,
    input  logic                    pd_dn,
    input  logic                    freeze,
    output logic signed [W_OUT-1:0] ctrl,
    output logic                    ctrl_vld,
`ifdef DMS_DLF_SAT_FLAG_EN
    output logic                    sat_hi,
    output logic                    sat_lo,
`endif
    output logic signed [W_OUT-1:0] integ
);

    // Counter needs at least one bit even when DECIM=1.
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    // Accumulator must hold +/-DECIM.
    localparam int AW = $clog2(DECIM) + 2;
    // Wide enough that neither shifted sum wraps before clamping.
    localparam int XW = W_OUT + AW + 2;

    localparam logic signed [XW-1:0] ONE_X = {{(XW-1){1'b0}}, 1'b1};
    localparam logic signed [XW-1:0] MAX_X = (ONE_X <<< (W_OUT - 1)) - ONE_X;
    localparam logic signed [XW-1:0] MIN_X = -(ONE_X <<< (W_OUT - 1));

    localparam longint MAX_L  = (longint'(1) <<< (W_OUT - 1)) - longint'(1);
    localparam longint MIN_L  = -(longint'(1) <<< (W_OUT - 1));
    localparam longint INIT_L = (longint'(INIT) > MAX_L) ? MAX_L :
                                (longint'(INIT) < MIN_L) ? MIN_L : longint'(INIT);
    localparam logic signed [W_OUT-1:0] INIT_SAT = INIT_L[W_OUT-1:0];

    function automatic logic signed [W_OUT-1:0] sat(input logic signed [XW-1:0] x);
        if (x > MAX_X) begin
            return MAX_X[W_OUT-1:0];
        end else if (x < MIN_X) begin
            return MIN_X[W_OUT-1:0];
        end else begin
            return x[W_OUT-1:0];
        end
    endfunction

    logic        [CW-1:0]    cnt;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    vote;
    logic signed [AW-1:0]    s_sum;
    logic                    close;
    logic signed [XW-1:0]    s_x;
    logic signed [XW-1:0]    integ_x;
    logic signed [XW-1:0]    integ_sum;
    logic signed [W_OUT-1:0] integ_next;
    logic signed [XW-1:0]    integ_next_x;
    logic signed [XW-1:0]    ctrl_sum;
    logic                    clamp_hi;
    logic                    clamp_lo;

    always_comb begin
        vote = '0;
        if (pd_up && !pd_dn) begin
            vote = {{(AW-1){1'b0}}, 1'b1};
        end else if (pd_dn && !pd_up) begin
            vote = '1;
        end
    end

    assign close = pd_vld && (cnt == CW'(DECIM - 1));
    assign s_sum = acc + vote;
    assign s_x   = {{(XW-AW){s_sum[AW-1]}}, s_sum};

    assign integ_x   = {{(XW-W_OUT){integ[W_OUT-1]}}, integ};
    assign integ_sum = integ_x + (s_x <<< KI_SHIFT);

    // Flags report a real clamp only, so a frozen update never sets them.
    assign clamp_hi = !freeze && (integ_sum > MAX_X);
    assign clamp_lo = !freeze && (integ_sum < MIN_X);

    assign integ_next   = freeze ? integ : sat(integ_sum);
    assign integ_next_x = {{(XW-W_OUT){integ_next[W_OUT-1]}}, integ_next};
    assign ctrl_sum     = integ_next_x + (s_x <<< KP_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            integ    <= INIT_SAT;
            ctrl     <= INIT_SAT;
            ctrl_vld <= 1'b0;
        end else begin
            ctrl_vld <= close;
            if (pd_vld) begin
                if (close) begin
                    cnt <= '0;
                    acc <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                    acc <= s_sum;
                end
            end
            if (close) begin
                integ <= integ_next;
                ctrl  <= sat(ctrl_sum);
            end
        end
    end

`ifdef DMS_DLF_SAT_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_hi <= 1'b0;
            sat_lo <= 1'b0;
        end else if (close) begin
            if (clamp_hi) sat_hi <= 1'b1;
            if (clamp_lo) sat_lo <= 1'b1;
        end
    end
`else
    logic unused_clamp;
    assign unused_clamp = clamp_hi ^ clamp_lo;
`endif

endmodule
